// File: rtl/parking_sensor_conditioner.sv
// Gate-sensor front end for smart_parking: synchronise, debounce and edge-detect
// two raw sensors, queue one event per channel, and issue the events as
// non-overlapping one-cycle pulses separated by a hold-off gap.
module parking_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_entry,
  input  logic raw_exit,
  input  logic ctrl_ready,
  input  logic err_clr,
  output logic sensor_entry,
  output logic sensor_exit,
  output logic entry_pend,
  output logic exit_pend,
  output logic entry_ovr,
  output logic exit_ovr
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0]  GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

  // Channel index 0 = entry, 1 = exit.
  logic [1:0]       raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       stable_q, stable_prev_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [1:0]       rise;
  logic [1:0]       pend_q, ovr_q;
  logic [1:0]       grant;
  state_e           state_q;
  logic             last_grant_q;  // 0 = entry, 1 = exit
  logic [GapW-1:0]  gap_q;

  assign raw  = {raw_exit, raw_entry};
  assign rise = stable_q & ~stable_prev_q;

  assign entry_pend = pend_q[0];
  assign exit_pend  = pend_q[1];
  assign entry_ovr  = ovr_q[0];
  assign exit_ovr   = ovr_q[1];

  // Two-flop synchroniser and debounce: stable follows sync2 only after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      cnt_q[0]      <= '0;
      cnt_q[1]      <= '0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DebLast) begin
          stable_q[i] <= sync2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Grant decision, only meaningful in idle with the controller ready; ties go
  // to the channel that was not served last.
  always_comb begin
    grant = 2'b00;
    if (state_q == StIdle && ctrl_ready) begin
      if (&pend_q) begin
        grant = last_grant_q ? 2'b01 : 2'b10;
      end else begin
        grant = pend_q;
      end
    end
  end

  // Pending and sticky overrun flags; a rise landing on a grant edge re-queues
  // the new event instead of counting as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        pend_q[i] <= rise[i] | (pend_q[i] & ~grant[i]);
        ovr_q[i]  <= (ovr_q[i] & ~err_clr) | (rise[i] & pend_q[i] & ~grant[i]);
      end
    end
  end

  // Issue FSM with registered pulse outputs: one pulse cycle, then the gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      gap_q        <= '0;
      sensor_entry <= 1'b0;
      sensor_exit  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            state_q      <= StPulse;
            sensor_entry <= grant[0];
            sensor_exit  <= grant[1];
            last_grant_q <= grant[1];
          end
        end
        StPulse: begin
          sensor_entry <= 1'b0;
          sensor_exit  <= 1'b0;
          gap_q        <= '0;
          state_q      <= (GAP_CYCLES > 0) ? StGap : StIdle;
        end
        StGap: begin
          if (gap_q == GapLast) begin
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_sensor_conditioner.sv
// Directed bench for parking_sensor_conditioner (DEBOUNCE_CYCLES=4, GAP_CYCLES=2).
module tb_parking_sensor_conditioner;

  logic clk = 1'b0;
  logic rst, raw_entry, raw_exit, ctrl_ready, err_clr;
  logic sensor_entry, sensor_exit, entry_pend, exit_pend, entry_ovr, exit_ovr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_entry  = 0;
  int n_exit   = 0;
  bit overlap_seen = 1'b0;
  int ev_ch[$];
  int ev_t[$];
  int base;

  parking_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8),
    .GAP_CYCLES     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .raw_entry   (raw_entry),
    .raw_exit    (raw_exit),
    .ctrl_ready  (ctrl_ready),
    .err_clr     (err_clr),
    .sensor_entry(sensor_entry),
    .sensor_exit (sensor_exit),
    .entry_pend  (entry_pend),
    .exit_pend   (exit_pend),
    .entry_ovr   (entry_ovr),
    .exit_ovr    (exit_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log, sampled mid-cycle.
  always @(negedge clk) begin
    if (sensor_entry && sensor_exit) overlap_seen = 1'b1;
    if (sensor_entry) begin
      n_entry++;
      ev_ch.push_back(0);
      ev_t.push_back(cyc);
    end
    if (sensor_exit) begin
      n_exit++;
      ev_ch.push_back(1);
      ev_t.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sensor_entry"}, 32'(sensor_entry), 0);
    chk({tag, "_sensor_exit"},  32'(sensor_exit),  0);
    chk({tag, "_entry_pend"},   32'(entry_pend),   0);
    chk({tag, "_exit_pend"},    32'(exit_pend),    0);
    chk({tag, "_entry_ovr"},    32'(entry_ovr),    0);
    chk({tag, "_exit_ovr"},     32'(exit_ovr),     0);
  endtask

  initial begin
    rst = 1'b1; raw_entry = 1'b0; raw_exit = 1'b0; ctrl_ready = 1'b1; err_clr = 1'b0;
    step(2);
    chk_all_zero("reset");
    rst = 1'b0;
    step(3);

    // 1: single entry event, pulse after edge 7, pending after edge 6 only.
    raw_entry = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("t1_entry_k%0d", k), 32'(sensor_entry), 32'(k == 7));
      chk($sformatf("t1_epend_k%0d", k), 32'(entry_pend), 32'(k == 6));
      chk($sformatf("t1_xpend_k%0d", k), 32'(exit_pend), 0);
    end
    raw_entry = 1'b0;
    step(12);
    chk("t1_entry_count", 32'(n_entry), 1);
    chk("t1_exit_count", 32'(n_exit), 0);

    // 2: 2-cycle glitches on raw_exit are filtered out.
    raw_exit = 1'b1; step(2);
    raw_exit = 1'b0; step(2);
    raw_exit = 1'b1; step(2);
    raw_exit = 1'b0; step(12);
    chk("t2_exit_count", 32'(n_exit), 0);
    chk("t2_exit_pend", 32'(exit_pend), 0);
    chk("t2_exit_ovr", 32'(exit_ovr), 0);
    chk("t2_entry_ovr", 32'(entry_ovr), 0);

    // 3: simultaneous edges from fresh reset: entry first, exit after the gap.
    rst = 1'b1; step(1);
    rst = 1'b0; step(2);
    raw_entry = 1'b1; raw_exit = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("t3_entry_k%0d", k), 32'(sensor_entry), 32'(k == 7));
      chk($sformatf("t3_exit_k%0d", k), 32'(sensor_exit), 32'(k == 11));
      chk($sformatf("t3_epend_k%0d", k), 32'(entry_pend), 32'(k == 6));
      chk($sformatf("t3_xpend_k%0d", k), 32'(exit_pend), 32'(k >= 6 && k <= 10));
    end
    raw_entry = 1'b0; raw_exit = 1'b0;
    step(10);

    // 4: two entry events while not ready: one kept, one lost and flagged.
    base = n_entry;
    ctrl_ready = 1'b0;
    raw_entry = 1'b1; step(8);
    raw_entry = 1'b0; step(8);
    raw_entry = 1'b1; step(8);
    raw_entry = 1'b0; step(8);
    chk("t4_entry_pend", 32'(entry_pend), 1);
    chk("t4_entry_ovr", 32'(entry_ovr), 1);
    chk("t4_exit_ovr", 32'(exit_ovr), 0);
    chk("t4_no_pulse_yet", 32'(n_entry - base), 0);
    ctrl_ready = 1'b1;
    tick();
    chk("t4_entry_pulse", 32'(sensor_entry), 1);
    chk("t4_entry_pend_clr", 32'(entry_pend), 0);
    step(6);
    chk("t4_single_pulse", 32'(n_entry - base), 1);
    chk("t4_ovr_sticky", 32'(entry_ovr), 1);
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    chk("t4_ovr_cleared", 32'(entry_ovr), 0);

    // 5: reset while in the gap with exit pending; held raw_exit re-fires.
    raw_entry = 1'b1; tick();
    raw_exit = 1'b1; step(8);
    chk("t5_pre_exit_pend", 32'(exit_pend), 1);
    chk("t5_pre_no_pulse", 32'(sensor_entry | sensor_exit), 0);
    rst = 1'b1; raw_entry = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    step(2);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("t5_exit_k%0d", k), 32'(sensor_exit), 32'(k == 7));
      chk($sformatf("t5_entry_k%0d", k), 32'(sensor_entry), 0);
    end
    raw_exit = 1'b0;
    step(10);

    // 6: four events (two tied pairs) alternate entry/exit with spacing.
    ev_ch.delete();
    ev_t.delete();
    for (int p = 0; p < 2; p++) begin
      raw_entry = 1'b1; raw_exit = 1'b1; step(16);
      raw_entry = 1'b0; raw_exit = 1'b0; step(10);
    end
    chk("t6_event_count", 32'(ev_ch.size()), 4);
    for (int i = 0; i < ev_ch.size(); i++) begin
      chk($sformatf("t6_order_%0d", i), 32'(ev_ch[i]), 32'(i % 2));
      if (i > 0) chk($sformatf("t6_spacing_%0d", i), 32'(ev_t[i] - ev_t[i-1] >= 3), 1);
    end
    chk("t6_entry_ovr", 32'(entry_ovr), 0);
    chk("t6_exit_ovr", 32'(exit_ovr), 0);
    chk("no_overlap", 32'(overlap_seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
